// File: rtl/xgemac_wb_regbank_if.sv
// Wishbone classic slave bus bundle for xgemac_wb_regbank.
// wb_err_o exists only when XGEMAC_WB_ERR_EN is defined.
interface xgemac_wb_regbank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] wb_adr_i;
   logic                  wb_cyc_i;
   logic                  wb_stb_i;
   logic                  wb_we_i;
   logic [DATA_WIDTH-1:0] wb_dat_i;
   logic [DATA_WIDTH-1:0] wb_dat_o;
   logic                  wb_ack_o;
`ifdef XGEMAC_WB_ERR_EN
   logic                  wb_err_o;

   modport master (
      output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );
   modport slave (
      input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
`else
   modport master (
      output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );
   modport slave (
      input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
`endif
endinterface

// File: rtl/xgemac_wb_regbank.sv
// Wishbone register bank: NUM_REGS RW registers, W1C IRQ status, IRQ mask, wait-state FSM.
// Define XGEMAC_WB_ERR_EN to answer unmapped accesses with wb_err_o instead of wb_ack_o.
module xgemac_wb_regbank #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int NUM_REGS    = 8,
   parameter int NUM_IRQ     = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_i,
   xgemac_wb_regbank_if.slave             wb,
   input  logic [NUM_IRQ-1:0]             irq_i,
   output logic                           wb_int_o,
   output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] MASK_ADDR   = ADDR_WIDTH'(NUM_REGS + 1);
   localparam logic [3:0]            CNT_INIT    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            cnt;
   logic [3:0]            cnt_nxt;
   logic                  req;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_IRQ-1:0]    irq_status;
   logic [NUM_IRQ-1:0]    irq_mask;
   logic [NUM_IRQ-1:0]    irq_clr;
   logic                  int_q;
   logic                  mapped;
   logic                  commit;
   logic [DATA_WIDTH-1:0] rd_data;

   assign req    = wb.wb_cyc_i & wb.wb_stb_i;
   assign mapped = (adr_q <= MASK_ADDR);
   assign commit = (state == ST_ACK) && we_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // WAIT counts down from WAIT_STATES-1 so it occupies exactly WAIT_STATES cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = ST_ACK;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nxt = ST_ACK;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      wb.wb_ack_o = 1'b0;
      wb.wb_dat_o = '0;
`ifdef XGEMAC_WB_ERR_EN
      wb.wb_err_o = 1'b0;
`endif
      if (state == ST_ACK) begin
`ifdef XGEMAC_WB_ERR_EN
         wb.wb_ack_o = mapped;
         wb.wb_err_o = !mapped;
`else
         wb.wb_ack_o = 1'b1;
`endif
         wb.wb_dat_o = rd_data;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         adr_q <= '0;
         we_q  <= 1'b0;
         dat_q <= '0;
      end else if (state == ST_IDLE && req) begin
         adr_q <= wb.wb_adr_i;
         we_q  <= wb.wb_we_i;
         dat_q <= wb.wb_dat_i;
      end
   end

   // Unmapped addresses fall through to zero, as do IRQ bits above NUM_IRQ.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (adr_q == ADDR_WIDTH'(k)) rd_data = regs[k];
      end
      if (adr_q == STATUS_ADDR) rd_data = DATA_WIDTH'(irq_status);
      if (adr_q == MASK_ADDR)   rd_data = DATA_WIDTH'(irq_mask);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else if (commit) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (adr_q == ADDR_WIDTH'(k)) regs[k] <= dat_q;
         end
      end
   end

   assign irq_clr = (commit && adr_q == STATUS_ADDR) ? dat_q[NUM_IRQ-1:0] : '0;

   // A new event on the same edge as its clear wins, so no event is lost.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         irq_status <= '0;
         irq_mask   <= '0;
         int_q      <= 1'b0;
      end else begin
         irq_status <= (irq_status & ~irq_clr) | irq_i;
         if (commit && adr_q == MASK_ADDR) irq_mask <= dat_q[NUM_IRQ-1:0];
         int_q <= |(irq_status & irq_mask);
      end
   end

   assign wb_int_o = int_q;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
      assign cfg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
   end

endmodule

// File: tb/tb_xgemac_wb_regbank.sv
// Scoreboard bench for xgemac_wb_regbank: one instance with 1 wait state, one with 3.
// Honours XGEMAC_WB_ERR_EN when the design is built with it.
module tb_xgemac_wb_regbank;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 8;
   localparam int NI = 8;
`ifdef XGEMAC_WB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      bit            s;
      bit            chk_data;
      logic [DW-1:0] data;
      bit            err;
      int            cycle;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              cyc, stb, we, sel;
   logic [AW-1:0]     adr;
   logic [DW-1:0]     dat;
   logic [NI-1:0]     irq1;
   logic [NI-1:0]     irq3;
   logic              int1, int3;
   logic [NR*DW-1:0]  cfg1, cfg3;
   logic              err1, err3, resp1, resp3;

   int                cycle_count = 0;
   int                n_cmp = 0;
   int                n_fail = 0;
   exp_t              sb[$];
   exp_t              mon_e;

   logic [DW-1:0]     m_regs [2][NR];
   logic [NI-1:0]     m_status [2];
   logic [NI-1:0]     m_mask [2];

   xgemac_wb_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
   xgemac_wb_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

   xgemac_wb_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_IRQ(NI), .WAIT_STATES(1)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(bus1), .irq_i(irq1), .wb_int_o(int1), .cfg_o(cfg1)
   );
   xgemac_wb_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_IRQ(NI), .WAIT_STATES(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(bus3), .irq_i(irq3), .wb_int_o(int3), .cfg_o(cfg3)
   );

   assign irq3 = '0;
   assign bus1.wb_cyc_i = cyc & ~sel;
   assign bus1.wb_stb_i = stb & ~sel;
   assign bus3.wb_cyc_i = cyc & sel;
   assign bus3.wb_stb_i = stb & sel;
   assign bus1.wb_adr_i = adr;
   assign bus3.wb_adr_i = adr;
   assign bus1.wb_we_i  = we;
   assign bus3.wb_we_i  = we;
   assign bus1.wb_dat_i = dat;
   assign bus3.wb_dat_i = dat;
`ifdef XGEMAC_WB_ERR_EN
   assign err1 = bus1.wb_err_o;
   assign err3 = bus3.wb_err_o;
`else
   assign err1 = 1'b0;
   assign err3 = 1'b0;
`endif
   assign resp1 = bus1.wb_ack_o | err1;
   assign resp3 = bus3.wb_ack_o | err3;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle_count <= cycle_count + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_count);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input bit s, input logic [AW-1:0] a);
      if (a < AW'(NR))        return m_regs[s][a];
      if (a == AW'(NR))       return DW'(m_status[s]);
      if (a == AW'(NR + 1))   return DW'(m_mask[s]);
      return '0;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < NR; k++) m_regs[b][k] = '0;
         m_status[b] = '0;
         m_mask[b]   = '0;
      end
   endtask

   // Pops one expectation per response seen on either bus.
   always @(negedge clk) begin
      if (resp1 || resp3) begin
         if (sb.size() == 0) begin
            check_output("unexpected_resp", {62'd0, resp3, resp1}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check_output("resp_bus", {62'd0, resp3, resp1}, mon_e.s ? 64'd2 : 64'd1);
            check_output("resp_latency", 64'(cycle_count), 64'(mon_e.cycle));
            check_output("ack", 64'(mon_e.s ? bus3.wb_ack_o : bus1.wb_ack_o), 64'(!mon_e.err));
            check_output("err", 64'(mon_e.s ? err3 : err1), 64'(mon_e.err));
            if (mon_e.chk_data)
               check_output("rd_data", 64'(mon_e.s ? bus3.wb_dat_o : bus1.wb_dat_o), 64'(mon_e.data));
         end
      end
   end

   task automatic apply_stimulus(input bit s, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [NI-1:0] irq_at_ack, input bit scramble);
      exp_t e;
      bit   got;
      @(negedge clk);
      sel = s; adr = a; we = w; dat = d; cyc = 1'b1; stb = 1'b1;
      e.s        = s;
      e.chk_data = !w;
      e.data     = model_read(s, a);
      e.err      = ERR_EN && (a > AW'(NR + 1));
      e.cycle    = cycle_count + 1 + (s ? 3 : 1);
      sb.push_back(e);
      if (scramble) begin
         @(negedge clk);
         adr = ~a; dat = ~d; we = ~w;
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (s ? resp3 : resp1) got = 1'b1;
      end
      if (got && !s) irq1 = irq_at_ack;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check_output("resp_seen", 64'(got), 64'd1);
      if (!got) void'(sb.pop_back());
      if (got && w) begin
         if (a < AW'(NR))            m_regs[s][a] = d;
         else if (a == AW'(NR))      m_status[s] = m_status[s] & ~d[NI-1:0];
         else if (a == AW'(NR + 1))  m_mask[s] = d[NI-1:0];
      end
      if (got && !s) m_status[s] = m_status[s] | irq_at_ack;
      @(negedge clk);
      irq1 = '0;
   endtask

   task automatic pulse_irq(input logic [NI-1:0] v);
      @(negedge clk);
      irq1 = v;
      @(negedge clk);
      irq1 = '0;
      m_status[0] = m_status[0] | v;
   endtask

   task automatic check_int();
      @(negedge clk);
      check_output("wb_int", 64'(int1), 64'(|(m_status[0] & m_mask[0])));
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic [NI-1:0] ri;
      bit            rw;
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b0;
      adr = '0; dat = '0; irq1 = '0;
      model_reset();
      repeat (3) @(negedge clk);
      irq1 = 8'hFF;
      @(negedge clk);
      irq1 = '0;
      check_output("rst_ack", 64'(bus1.wb_ack_o), 64'd0);
      check_output("rst_dat", 64'(bus1.wb_dat_o), 64'd0);
      check_output("rst_int", 64'(int1), 64'd0);
      for (int k = 0; k < NR; k++) check_output("rst_cfg", 64'(cfg1[k*DW +: DW]), 64'd0);
      rst_n = 1'b1;
      // irq pulses during reset must leave status clear
      apply_stimulus(0, 1'b0, AW'(NR), '0, '0, 1'b0);

      $display("[TB] write/read addr 3");
      apply_stimulus(0, 1'b1, 8'd3, 32'hDEADBEEF, '0, 1'b0);
      check_output("cfg_reg3", 64'(cfg1[3*DW +: DW]), 64'hDEADBEEF);
      apply_stimulus(0, 1'b0, 8'd3, '0, '0, 1'b0);

      $display("[TB] irq mask and W1C");
      apply_stimulus(0, 1'b1, AW'(NR + 1), 32'h04, '0, 1'b0);
      pulse_irq(8'h04);
      check_output("int_lag", 64'(int1), 64'd0);
      @(negedge clk);
      check_output("int_set", 64'(int1), 64'd1);
      apply_stimulus(0, 1'b0, AW'(NR), '0, '0, 1'b0);
      apply_stimulus(0, 1'b1, AW'(NR), 32'h04, '0, 1'b0);
      check_int();
      apply_stimulus(0, 1'b0, AW'(NR), '0, '0, 1'b0);

      $display("[TB] W1C coincident with irq");
      pulse_irq(8'h04);
      check_int();
      apply_stimulus(0, 1'b1, AW'(NR), 32'h04, 8'h04, 1'b0);
      apply_stimulus(0, 1'b0, AW'(NR), '0, '0, 1'b0);
      check_int();

      $display("[TB] unmapped access");
      apply_stimulus(0, 1'b1, AW'(NR + 2), 32'hFFFF_FFFF, '0, 1'b0);
      apply_stimulus(0, 1'b0, AW'(NR + 2), '0, '0, 1'b0);

      $display("[TB] aborted write, 3 wait states");
      apply_stimulus(1, 1'b1, 8'd0, 32'h1234_5678, '0, 1'b0);
      @(negedge clk);
      sel = 1'b1; adr = 8'd0; we = 1'b1; dat = 32'hCAFE_F00D; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (6) @(negedge clk);
      check_output("abort_reg0", 64'(cfg3[0 +: DW]), 64'h1234_5678);
      apply_stimulus(1, 1'b0, 8'd0, '0, '0, 1'b0);
      apply_stimulus(1, 1'b1, 8'd1, 32'hA5A5_0001, '0, 1'b1);
      check_output("latched_reg1", 64'(cfg3[DW +: DW]), 64'hA5A5_0001);
      apply_stimulus(1, 1'b0, 8'd1, '0, '0, 1'b0);

      $display("[TB] reset during wait");
      @(negedge clk);
      sel = 1'b0; adr = 8'd5; we = 1'b1; dat = 32'h5555_AAAA; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_output("rstw_ack", 64'(bus1.wb_ack_o), 64'd0);
      check_output("rstw_dat", 64'(bus1.wb_dat_o), 64'd0);
      check_output("rstw_int", 64'(int1), 64'd0);
      check_output("rstw_reg3", 64'(cfg1[3*DW +: DW]), 64'd0);
      check_output("rstw_dut3_reg0", 64'(cfg3[0 +: DW]), 64'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_output("rstw_reg5", 64'(cfg1[5*DW +: DW]), 64'd0);
      apply_stimulus(0, 1'b1, 8'd5, 32'h0BAD_F00D, '0, 1'b0);
      apply_stimulus(0, 1'b0, 8'd5, '0, '0, 1'b0);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0) pulse_irq(NI'($urandom));
         ra = AW'($urandom_range(0, NR + 3));
         rw = 1'($urandom_range(0, 1));
         rd = DW'($urandom);
         ri = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
         apply_stimulus(0, rw, ra, rd, ri, 1'b0);
         if (ra < AW'(NR)) check_output("rand_cfg", 64'(cfg1[int'(ra)*DW +: DW]), 64'(m_regs[0][ra]));
         check_int();
      end

      repeat (4) @(negedge clk);
      check_output("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
